// File: rtl/cyclic_encoder_llr.sv
// Systematic shortened-BCH encoder with a noiseless BPSK LLR image.
// A message is accepted in IDLE (or in DONE while the output retires).
// Parity is then built serially by an LFSR, one message bit per cycle, MSB first.
// The codeword {msg, parity} and its LLR lanes are registered and held until out_ready.
module cyclic_encoder_llr #(
  parameter int                WIDTH    = 8,
  parameter int                N_V      = 44,
  parameter int                K        = 26,
  parameter logic [N_V-K:0]    GEN_POLY = 19'h782CF,
  parameter int                LLR_MAG  = 7
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [K-1:0]         msg,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N_V-1:0]       codeword,
  output logic [WIDTH*N_V-1:0] all_llrs
);

  localparam int R     = N_V - K;
  localparam int CNT_W = (K > 1) ? $clog2(K) : 1;

  localparam logic [WIDTH-1:0] LLR_POS = WIDTH'(LLR_MAG);
  localparam logic [WIDTH-1:0] LLR_NEG = WIDTH'(-LLR_MAG);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [K-1:0]         msg_q, msg_d;
  logic [R-1:0]         lfsr_q, lfsr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [N_V-1:0]       cw_q, cw_d;
  logic [WIDTH*N_V-1:0] llr_q, llr_d;
  logic                 out_valid_q, out_valid_d;

  logic                 accept;
  logic                 fb;
  logic [R-1:0]         lfsr_nxt;
  logic [N_V-1:0]       cw_nxt;
  logic [WIDTH*N_V-1:0] llr_nxt;

  // Next-state logic and the combinational handshake. in_ready is also
  // high in DONE when the consumer takes the output, so a new message can be
  // accepted on the same edge that the previous codeword retires.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement leaves it unassigned and no latch is inferred.
    state_d  = state_q;
    in_ready = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = S_SHIFT;
      end
      S_SHIFT: begin
        if (cnt_q == '0) state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready) begin
          in_ready = 1'b1;
          state_d  = in_valid ? S_SHIFT : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign accept = in_valid & in_ready;

  // One LFSR step: divide by g(x) with the current message bit fed into the top.
  always_comb begin
    fb       = msg_q[cnt_q] ^ lfsr_q[R-1];
    lfsr_nxt = {lfsr_q[R-2:0], 1'b0} ^ (fb ? GEN_POLY[R-1:0] : '0);
    cw_nxt   = {msg_q, lfsr_nxt};
    for (int i = 0; i < N_V; i++) begin
      llr_nxt[WIDTH*i +: WIDTH] = cw_nxt[i] ? LLR_NEG : LLR_POS;
    end
  end

  // Datapath next-state: latch on accept, shift while in SHIFT, register the
  // outputs on the last shift, drop out_valid when the output is taken.
  always_comb begin
    msg_d       = msg_q;
    lfsr_d      = lfsr_q;
    cnt_d       = cnt_q;
    cw_d        = cw_q;
    llr_d       = llr_q;
    out_valid_d = out_valid_q;
    if (accept) begin
      msg_d       = msg;
      lfsr_d      = '0;
      cnt_d       = CNT_W'(K - 1);
      out_valid_d = 1'b0;
    end else if (state_q == S_SHIFT) begin
      lfsr_d = lfsr_nxt;
      if (cnt_q == '0) begin
        cw_d        = cw_nxt;
        llr_d       = llr_nxt;
        out_valid_d = 1'b1;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end else if ((state_q == S_DONE) && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Datapath registers; all are cleared so an aborted message leaves no trace.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      msg_q       <= '0;
      lfsr_q      <= '0;
      cnt_q       <= '0;
      cw_q        <= '0;
      llr_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      msg_q       <= msg_d;
      lfsr_q      <= lfsr_d;
      cnt_q       <= cnt_d;
      cw_q        <= cw_d;
      llr_q       <= llr_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign codeword  = cw_q;
  assign all_llrs  = llr_q;

endmodule

// File: tb/tb_cyclic_encoder_llr.sv
// Directed plus random bench for cyclic_encoder_llr. Expected codewords come
// from straight polynomial long division of msg(x)*x^R by g(x).
module tb_cyclic_encoder_llr;

  localparam int               WIDTH    = 8;
  localparam int               N_V      = 44;
  localparam int               K        = 26;
  localparam int               R        = N_V - K;
  localparam logic [R:0]       GEN_POLY = 19'h782CF;
  localparam int               LLR_MAG  = 7;
  localparam int               LW       = WIDTH * N_V;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [K-1:0]   msg;
  logic           out_valid;
  logic           out_ready;
  logic [N_V-1:0] codeword;
  logic [LW-1:0]  all_llrs;

  int total = 0;
  int bad   = 0;

  cyclic_encoder_llr #(
    .WIDTH(WIDTH), .N_V(N_V), .K(K), .GEN_POLY(GEN_POLY), .LLR_MAG(LLR_MAG)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .msg(msg), .out_valid(out_valid), .out_ready(out_ready),
    .codeword(codeword), .all_llrs(all_llrs)
  );

  always #5 clk = ~clk;

  // Remainder of v(x) divided by g(x), by schoolbook long division.
  function automatic logic [R-1:0] poly_mod(input logic [N_V-1:0] v);
    logic [N_V-1:0] g;
    g = N_V'(GEN_POLY);
    for (int i = N_V - 1; i >= R; i--) begin
      if (v[i]) v = v ^ (g << (i - R));
    end
    return v[R-1:0];
  endfunction

  function automatic logic [N_V-1:0] model_cw(input logic [K-1:0] m);
    logic [N_V-1:0] shifted;
    shifted = {m, {R{1'b0}}};
    return {m, poly_mod(shifted)};
  endfunction

  function automatic logic [LW-1:0] model_llr(input logic [N_V-1:0] cw);
    logic [LW-1:0] l;
    int            mag;
    for (int i = 0; i < N_V; i++) begin
      mag = cw[i] ? -LLR_MAG : LLR_MAG;
      l[WIDTH*i +: WIDTH] = WIDTH'(mag);
    end
    return l;
  endfunction

  task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a message for exactly one edge from IDLE.
  task automatic send(input logic [K-1:0] m);
    check("in_ready_before_send", LW'(in_ready), LW'(1'b1));
    msg      = m;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    msg      = K'($urandom);
  endtask

  // Count edges until out_valid rises; bounded so a dead DUT cannot hang the run.
  task automatic wait_out(output int cyc);
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 200) begin
      tick();
      cyc++;
      if (cyc == 5) check("in_ready_low_in_shift", LW'(in_ready), LW'(1'b0));
    end
  endtask

  task automatic check_out(input string tag, input logic [K-1:0] m);
    logic [N_V-1:0] exp_cw;
    exp_cw = model_cw(m);
    check({tag, "_codeword"}, LW'(codeword), LW'(exp_cw));
    check({tag, "_llrs"}, all_llrs, model_llr(exp_cw));
  endtask

  initial begin
    int             cyc;
    int             abs_cyc;
    logic [K-1:0]   m;
    logic [K-1:0]   ms [3];
    logic [N_V-1:0] snap_cw;
    logic [LW-1:0]  snap_llr;
    logic [N_V-1:0] dut_cw;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    msg       = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", LW'(out_valid), LW'(1'b0));
    check("reset_codeword", LW'(codeword), '0);
    check("reset_llrs", all_llrs, '0);
    check("reset_in_ready", LW'(in_ready), LW'(1'b1));
    rst_n = 1'b1;
    tick();

    // All-zero message.
    out_ready = 1'b1;
    send('0);
    wait_out(cyc);
    check("zero_latency", LW'(cyc), LW'(K));
    check_out("zero", '0);
    check("zero_lane0", LW'(all_llrs[7:0]), LW'(8'h07));
    check("zero_in_ready_done", LW'(in_ready), LW'(1'b1));
    tick();
    check("zero_retire", LW'(out_valid), LW'(1'b0));

    // msg = 1 gives exactly g(x).
    send(K'(1));
    wait_out(cyc);
    check("one_latency", LW'(cyc), LW'(K));
    check("one_codeword_const", LW'(codeword), LW'(44'h782CF));
    check_out("one", K'(1));
    check("one_lane0", LW'(all_llrs[7:0]), LW'(8'hF9));
    check("one_lane4", LW'(all_llrs[39:32]), LW'(8'h07));
    check("one_lane18", LW'(all_llrs[151:144]), LW'(8'hF9));
    tick();
    check("one_retire", LW'(out_valid), LW'(1'b0));

    // Backpressure for 50 cycles.
    out_ready = 1'b0;
    m = K'($urandom);
    send(m);
    wait_out(cyc);
    check("bp_latency", LW'(cyc), LW'(K));
    check_out("bp", m);
    snap_cw  = codeword;
    snap_llr = all_llrs;
    for (int i = 0; i < 50; i++) begin
      tick();
      check("bp_valid_held", LW'(out_valid), LW'(1'b1));
      check("bp_cw_held", LW'(codeword), LW'(snap_cw));
      check("bp_llr_held", all_llrs, snap_llr);
      check("bp_in_ready_low", LW'(in_ready), LW'(1'b0));
    end
    out_ready = 1'b1;
    #1;
    check("bp_in_ready_release", LW'(in_ready), LW'(1'b1));
    tick();
    check("bp_retire", LW'(out_valid), LW'(1'b0));

    // Back-to-back: accepts at 0, 27, 54; outputs at 26, 53, 80.
    for (int j = 0; j < 3; j++) ms[j] = K'($urandom);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    msg       = ms[0];
    tick();
    abs_cyc = 0;
    for (int j = 0; j < 3; j++) begin
      msg = (j < 2) ? ms[j+1] : K'($urandom);
      wait_out(cyc);
      abs_cyc += cyc;
      check("b2b_out_time", LW'(abs_cyc), LW'(K + (K + 1) * j));
      check_out("b2b", ms[j]);
      check("b2b_in_ready", LW'(in_ready), LW'(1'b1));
      if (j == 2) in_valid = 1'b0;
      tick();
      abs_cyc++;
      check("b2b_retire", LW'(out_valid), LW'(1'b0));
    end

    // Reset in the middle of SHIFT.
    send(K'($urandom));
    repeat (10) tick();
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", LW'(out_valid), LW'(1'b0));
    check("midrst_codeword", LW'(codeword), '0);
    check("midrst_llrs", all_llrs, '0);
    check("midrst_in_ready", LW'(in_ready), LW'(1'b1));
    tick();
    rst_n = 1'b1;
    tick();
    m = K'($urandom);
    send(m);
    wait_out(cyc);
    check("midrst_latency", LW'(cyc), LW'(K));
    check_out("midrst", m);
    tick();

    // Random messages with random backpressure.
    for (int n = 0; n < 1000; n++) begin
      out_ready = 1'b0;
      m = K'($urandom);
      send(m);
      wait_out(cyc);
      check("rnd_latency", LW'(cyc), LW'(K));
      check_out("rnd", m);
      dut_cw = codeword;
      check("rnd_divisible", LW'(poly_mod(dut_cw)), '0);
      check("rnd_upper_msg", LW'(dut_cw[N_V-1:R]), LW'(m));
      repeat ($urandom_range(0, 3)) tick();
      out_ready = 1'b1;
      tick();
      check("rnd_retire", LW'(out_valid), LW'(1'b0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
